// File: rtl/idecoder_seq.sv
// rtl/idecoder_seq.sv - queued instruction decoder sequencing register read, execute and writeback phases
module idecoder_seq #(
    parameter int DW     = 16,
    parameter int QDEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_instr,
    input  logic          stall,
    output logic [2:0]    opcode,
    output logic [1:0]    alu_op,
    output logic [1:0]    shift_op,
    output logic [DW-1:0] sximm5,
    output logic [DW-1:0] sximm8,
    output logic [2:0]    r_addr,
    output logic [2:0]    w_addr,
    output logic          load_a,
    output logic          load_b,
    output logic          load_c,
    output logic          load_s,
    output logic          asel,
    output logic          wen,
    output logic          vsel,
    output logic          illegal,
    output logic          busy,
    output logic [2:0]    phase
);
    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [AW:0] QFULL = QDEPTH[AW:0];

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DEC  = 3'd1,
        S_RDA  = 3'd2,
        S_RDB  = 3'd3,
        S_EXE  = 3'd4,
        S_WB   = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [15:0]   r_mem [QDEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [15:0]   r_ir;
    logic [2:0]    r_raddr_hold;
    logic [2:0]    r_waddr_hold;

    logic          w_push;
    logic          w_pop;
    logic          w_end;
    logic          w_full;
    logic          w_empty;
    logic [2:0]    w_rn;
    logic [2:0]    w_rd;
    logic [2:0]    w_rm;
    logic          w_mov_imm;
    logic          w_mov_sh;
    logic          w_alu;
    logic          w_cmp;
    logic          w_mvn;
    logic          w_legal;

    // Field extraction and instruction class, all pure functions of IR
    always_comb begin
        opcode    = r_ir[15:13];
        alu_op    = r_ir[12:11];
        shift_op  = r_ir[4:3];
        sximm5    = {{(DW-5){r_ir[4]}}, r_ir[4:0]};
        sximm8    = {{(DW-8){r_ir[7]}}, r_ir[7:0]};
        w_rn      = r_ir[10:8];
        w_rd      = r_ir[7:5];
        w_rm      = r_ir[2:0];
        w_mov_imm = (r_ir[15:13] == 3'b110) && (r_ir[12:11] == 2'b10);
        w_mov_sh  = (r_ir[15:13] == 3'b110) && (r_ir[12:11] == 2'b00);
        w_alu     = (r_ir[15:13] == 3'b101);
        w_cmp     = w_alu && (r_ir[12:11] == 2'b01);
        w_mvn     = w_alu && (r_ir[12:11] == 2'b11);
        w_legal   = w_mov_imm | w_mov_sh | w_alu;
    end

    // Queue status; a full queue refuses pushes even if a pop happens the same cycle
    always_comb begin
        w_full   = (r_count == QFULL);
        w_empty  = (r_count == '0);
        in_ready = !w_full;
        w_push   = in_valid && !w_full;
        busy     = (r_state != S_IDLE) || !w_empty;
        phase    = r_state;
    end

    // Next state and phase strobes; stall freezes the state and silences every strobe
    always_comb begin
        w_next  = r_state;
        w_end   = 1'b0;
        load_a  = 1'b0;
        load_b  = 1'b0;
        load_c  = 1'b0;
        load_s  = 1'b0;
        asel    = 1'b0;
        wen     = 1'b0;
        vsel    = 1'b0;
        illegal = 1'b0;
        case (r_state)
            S_IDLE: w_end = 1'b1;
            S_DEC: begin
                if (!w_legal) begin
                    illegal = 1'b1;
                    w_end   = 1'b1;
                end else if (w_mov_imm) begin
                    w_next = S_WB;
                end else if (w_mov_sh || w_mvn) begin
                    w_next = S_RDB;
                end else begin
                    w_next = S_RDA;
                end
            end
            S_RDA: begin
                load_a = 1'b1;
                w_next = S_RDB;
            end
            S_RDB: begin
                load_b = 1'b1;
                w_next = S_EXE;
            end
            S_EXE: begin
                load_c = 1'b1;
                load_s = w_alu;
                asel   = w_mov_sh | w_mvn;
                if (w_cmp) w_end = 1'b1;
                else       w_next = S_WB;
            end
            S_WB: begin
                wen   = 1'b1;
                vsel  = w_mov_imm;
                w_end = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
        w_pop = w_end && !stall && !w_empty;
        if (stall) begin
            w_next  = r_state;
            load_a  = 1'b0;
            load_b  = 1'b0;
            load_c  = 1'b0;
            load_s  = 1'b0;
            asel    = 1'b0;
            wen     = 1'b0;
            vsel    = 1'b0;
            illegal = 1'b0;
        end else if (w_end) begin
            w_next = w_pop ? S_DEC : S_IDLE;
        end
    end

    // Register addresses are driven in their phase and otherwise keep the last driven value
    always_comb begin
        case (r_state)
            S_RDA:   r_addr = w_rn;
            S_RDB:   r_addr = w_rm;
            default: r_addr = r_raddr_hold;
        endcase
        w_addr = (r_state == S_WB) ? (w_mov_imm ? w_rn : w_rd) : r_waddr_hold;
    end

    // Queue storage; contents need no reset because occupancy is tracked by r_count
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= in_instr;
    end

    // Queue pointers, IR, FSM state and address hold registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_ir         <= '0;
            r_state      <= S_IDLE;
            r_raddr_hold <= '0;
            r_waddr_hold <= '0;
        end else begin
            r_state      <= w_next;
            r_raddr_hold <= r_addr;
            r_waddr_hold <= w_addr;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_ir   <= r_mem[r_rptr];
            end
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end
endmodule

// File: tb/tb_idecoder_seq.sv
// tb/tb_idecoder_seq.sv - self-checking bench for idecoder_seq against a phase-list reference model
module tb_idecoder_seq;
    localparam int DW = 16;
    localparam int QD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_instr;
    logic          stall;
    logic [2:0]    opcode;
    logic [1:0]    alu_op;
    logic [1:0]    shift_op;
    logic [DW-1:0] sximm5;
    logic [DW-1:0] sximm8;
    logic [2:0]    r_addr;
    logic [2:0]    w_addr;
    logic          load_a, load_b, load_c, load_s, asel, wen, vsel, illegal, busy;
    logic [2:0]    phase;

    idecoder_seq #(.DW(DW), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .stall(stall), .opcode(opcode), .alu_op(alu_op), .shift_op(shift_op),
        .sximm5(sximm5), .sximm8(sximm8), .r_addr(r_addr), .w_addr(w_addr),
        .load_a(load_a), .load_b(load_b), .load_c(load_c), .load_s(load_s), .asel(asel),
        .wen(wen), .vsel(vsel), .illegal(illegal), .busy(busy), .phase(phase)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending instructions, the current IR and the list of phases it still has to visit
    logic [15:0] m_fifo[$];
    logic [15:0] m_ir;
    int          m_seq[$];
    logic [2:0]  m_last_r;
    logic [2:0]  m_last_w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_seq(input logic [15:0] ir);
        logic [2:0] opc;
        logic [1:0] op;
        opc = ir[15:13];
        op  = ir[12:11];
        if (opc == 3'd6 && op == 2'd2)      m_seq = '{1, 5};
        else if (opc == 3'd6 && op == 2'd0) m_seq = '{1, 3, 4, 5};
        else if (opc == 3'd5 && op == 2'd1) m_seq = '{1, 2, 3, 4};
        else if (opc == 3'd5 && op == 2'd3) m_seq = '{1, 3, 4, 5};
        else if (opc == 3'd5)               m_seq = '{1, 2, 3, 4, 5};
        else                                m_seq = '{1};
    endtask

    function automatic int m_phase();
        return (m_seq.size() != 0) ? m_seq[0] : 0;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_seq.delete();
        m_ir     = 16'h0000;
        m_last_r = 3'd0;
        m_last_w = 3'd0;
    endtask

    task automatic check_outputs();
        int         ph;
        bit         act;
        bit         movi;
        bit         movsh;
        bit         mvn;
        int         v5;
        int         v8;
        logic [2:0] er;
        logic [2:0] ew;
        ph    = m_phase();
        act   = !stall;
        movi  = (m_ir[15:13] == 3'd6) && (m_ir[12:11] == 2'd2);
        movsh = (m_ir[15:13] == 3'd6) && (m_ir[12:11] == 2'd0);
        mvn   = (m_ir[15:13] == 3'd5) && (m_ir[12:11] == 2'd3);
        v5    = int'(m_ir[4:0]);
        if (v5 >= 16) v5 -= 32;
        v8    = int'(m_ir[7:0]);
        if (v8 >= 128) v8 -= 256;
        er = (ph == 2) ? m_ir[10:8] : (ph == 3) ? m_ir[2:0] : m_last_r;
        ew = (ph == 5) ? (movi ? m_ir[10:8] : m_ir[7:5]) : m_last_w;
        m_last_r = er;
        m_last_w = ew;
        chk("phase",    32'(phase),    32'(ph));
        chk("in_ready", 32'(in_ready), 32'(m_fifo.size() < QD));
        chk("busy",     32'(busy),     32'(ph != 0 || m_fifo.size() != 0));
        chk("opcode",   32'(opcode),   32'(m_ir[15:13]));
        chk("alu_op",   32'(alu_op),   32'(m_ir[12:11]));
        chk("shift_op", 32'(shift_op), 32'(m_ir[4:3]));
        chk("sximm5",   32'(sximm5),   32'(v5[DW-1:0]));
        chk("sximm8",   32'(sximm8),   32'(v8[DW-1:0]));
        chk("r_addr",   32'(r_addr),   32'(er));
        chk("w_addr",   32'(w_addr),   32'(ew));
        chk("load_a",   32'(load_a),   32'(act && ph == 2));
        chk("load_b",   32'(load_b),   32'(act && ph == 3));
        chk("load_c",   32'(load_c),   32'(act && ph == 4));
        chk("load_s",   32'(load_s),   32'(act && ph == 4 && m_ir[15:13] == 3'd5));
        chk("asel",     32'(asel),     32'(act && ph == 4 && (movsh || mvn)));
        chk("wen",      32'(wen),      32'(act && ph == 5));
        chk("vsel",     32'(vsel),     32'(act && ph == 5 && movi));
        chk("illegal",  32'(illegal),  32'(act && ph == 1 && m_seq.size() == 1));
    endtask

    task automatic model_step();
        bit can_push;
        can_push = in_valid && (m_fifo.size() < QD);
        if (!stall) begin
            if (m_seq.size() != 0) void'(m_seq.pop_front());
            if (m_seq.size() == 0 && m_fifo.size() != 0) begin
                m_ir = m_fifo.pop_front();
                build_seq(m_ir);
            end
        end
        if (can_push) m_fifo.push_back(in_instr);
    endtask

    task automatic cycle(input bit v, input logic [15:0] ins, input bit st);
        in_valid = v;
        in_instr = ins;
        stall    = st;
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        stall    = 1'b0;
        model_reset();
        #1;
        chk("rst_phase",  32'(phase),  32'd0);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_wen",    32'(wen),    32'd0);
        chk("rst_r_addr", 32'(r_addr), 32'd0);
        chk("rst_w_addr", 32'(w_addr), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_until(input int target, input int budget);
        int n;
        n = 0;
        while (m_phase() != target && n < budget) begin
            cycle(1'b0, 16'h0000, 1'b0);
            n++;
        end
        chk("reach_phase", 32'(phase), 32'(target));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0000, 1'b0);
    endtask

    initial begin
        logic [15:0] r;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_instr = 16'h0000;
        stall    = 1'b0;
        #2;
        do_reset();

        // MOV R0,#7
        cycle(1'b1, 16'hD007, 1'b0);
        run_until(5, 10);
        chk("movi_wen",    32'(wen),    32'd1);
        chk("movi_w_addr", 32'(w_addr), 32'd0);
        chk("movi_vsel",   32'(vsel),   32'd1);
        chk("movi_sximm8", 32'(sximm8), 32'h0007);
        idle(3);

        // ADD R2,R1,R0
        cycle(1'b1, 16'hA140, 1'b0);
        run_until(2, 10);
        chk("add_rda", 32'(r_addr), 32'd1);
        idle(1);
        chk("add_rdb", 32'(r_addr), 32'd0);
        idle(1);
        chk("add_exe", 32'({load_c, load_s}), 32'd3);
        idle(1);
        chk("add_wb",  32'({wen, w_addr}), 32'({1'b1, 3'd2}));
        idle(3);

        // CMP R1,R0 then an undecodable word
        cycle(1'b1, 16'hA900, 1'b0);
        idle(7);
        cycle(1'b1, 16'h0000, 1'b0);
        idle(4);

        // Fill the queue while stalled, then drain
        cycle(1'b1, 16'hA140, 1'b1);
        cycle(1'b1, 16'hD0F5, 1'b1);
        chk("full_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, 16'hA900, 1'b1);
        idle(16);
        chk("drain_idle", 32'(busy), 32'd0);

        // MOV R3,R1,LSL#1 with a stall held in RDB
        cycle(1'b1, 16'hC069, 1'b0);
        run_until(3, 10);
        cycle(1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);
        chk("stall_r_addr", 32'(r_addr), 32'd1);
        run_until(5, 10);
        chk("movsh_shift",  32'(shift_op), 32'd1);
        chk("movsh_w_addr", 32'(w_addr),   32'd3);
        idle(2);

        // Reset during EXE of ADD with one instruction queued
        cycle(1'b1, 16'hA140, 1'b0);
        cycle(1'b1, 16'hA140, 1'b0);
        run_until(4, 10);
        do_reset();
        chk("midrst_ready", 32'(in_ready), 32'd1);
        cycle(1'b1, 16'hD0FF, 1'b0);
        idle(5);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r = 16'($urandom);
            case ($urandom_range(0, 3))
                0: r[15:11] = {3'b110, 1'b0, r[12]};
                1: r[15:13] = 3'b101;
                2: r[15:11] = {3'b110, 1'b1, 1'b0};
                default: ;
            endcase
            cycle(1'($urandom_range(0, 1)), r, $urandom_range(0, 4) == 0);
        end
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
